pipe_stage_skid: RTL and testbench

//  Generic elastic pipeline stage register. It replaces the fixed-field, always-load stage registers between pipeline stages.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_stage_skid_if.sv | 34 +++
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and stage-boundary widths for elastic pipeline stages
//
// Purpose: occupancy encoding for the stage FSM, the NOP control word, and
// default control/payload widths for each processor stage boundary.
// Ports: none (package).
package pipe_pkg;

  // Occupancy doubles as the FSM state: the encoding is the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Widest control word any boundary uses; stages cast down to their own width.
  localparam int CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

  localparam int ID_EXE_CTRL_W  = 17;
  localparam int ID_EXE_DATA_W  = 128;
  localparam int EXE_MEM_CTRL_W = 12;
  localparam int EXE_MEM_DATA_W = 96;
  localparam int MEM_WB_CTRL_W  = 8;
  localparam int MEM_WB_DATA_W  = 72;
  localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready handshake bundle carrying control word and payload
//
// Purpose: one direction of a stage-to-stage link.
// Signals:
//   valid  producer offers ctrl/data
//   ready  consumer accepts this cycle
//   ctrl   control word (all-zero = NOP bubble)
//   data   packed payload
// Modports: master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 17,
  parameter int DATA_W = 128
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register with load and clear
//
// Purpose: a single entry of the stage storage. Contents change only on
// load or clear; otherwise the entry is held untouched.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               drop the entry (valid, ctrl, data all zeroed); wins over load
//   load              capture d_ctrl/d_data and mark valid
//   d_ctrl, d_data    incoming entry
//   q_valid, q_ctrl, q_data  held entry
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 17,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_W'(CTRL_NOP);
      q_data  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage register with 2-entry skid buffer
//
// Purpose: registered valid/ready stage between two processor stages.
// A main slot drives the outputs; a skid slot absorbs the one extra entry
// that can arrive while the registered upstream ready is still high.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         squash held and incoming entries this cycle
//   up            upstream link (slave): valid/ctrl/data in, ready out (registered)
//   dn            downstream link (master): valid/ctrl/data out, ready in
//   o_occ         entries held (0, 1, 2)
//   o_stall_cnt   saturating count of cycles with dn.valid & !dn.ready
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EXE_CTRL_W,
  parameter int DATA_W = ID_EXE_DATA_W,
  parameter int CNT_W  = STALL_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_if.slave      up,
  pipe_stage_skid_if.master     dn,
  output logic [1:0]            o_occ,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  occ_e state_q, state_d;
  logic ready_q;
  logic accept, drain;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;

  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;

  logic [CNT_W-1:0] stall_q;

  assign accept = up.valid & ready_q;
  assign drain  = main_valid & dn.ready;

  // State register. Ready is computed from the next state so that it is a
  // flop output and is already low whenever the stage sits in FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != OCC_FULL);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (accept) state_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !drain)      state_d = OCC_FULL;
          else if (!accept && drain) state_d = OCC_EMPTY;
        end
        OCC_FULL: if (drain) state_d = OCC_ONE;
        default:  state_d = OCC_EMPTY;
      endcase
    end
  end

  // Slot control. Draining to empty clears the main slot so the outgoing
  // control word reads as a NOP whenever valid is low.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: main_load = accept;
        OCC_ONE: begin
          if (accept && drain)       main_load = 1'b1;
          else if (accept && !drain) skid_load = 1'b1;
          else if (drain)            main_clr  = 1'b1;
        end
        OCC_FULL: begin
          if (drain) begin
            main_load      = skid_valid;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : up.ctrl;
  assign main_d_data = main_from_skid ? skid_data : up.data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (main_clr),
    .load    (main_load),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (skid_clr),
    .load    (skid_load),
    .d_ctrl  (up.ctrl),
    .d_data  (up.data),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign up.ready    = ready_q;
  assign dn.valid    = main_valid;
  assign dn.ctrl     = main_ctrl;
  assign dn.data     = main_data;
  assign o_occ       = state_q;
  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed table-driven bench for pipe_stage_skid
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = 17;
  localparam int DW = 128;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [1:0]    occ;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .up          (up_if),
    .dn          (dn_if),
    .o_occ       (occ),
    .o_stall_cnt (stall_cnt)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic       ir;
    logic [7:0] id;
    logic       ev;
    logic       er;
    logic [1:0] eocc;
    logic [7:0] eid;
    logic [3:0] est;
    logic       cd;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[22];

  function automatic logic [CW-1:0] mk_ctrl(input logic [7:0] id);
    return {1'b1, 8'h00, id};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [7:0] id);
    return {16{id}};
  endfunction

  function automatic vec_t v(input logic fl, iv, ir, input logic [7:0] id,
                             input logic ev, er, input logic [1:0] eocc,
                             input logic [7:0] eid, input logic [3:0] est,
                             input logic cd);
    vec_t r;
    r.fl = fl; r.iv = iv; r.ir = ir; r.id = id;
    r.ev = ev; r.er = er; r.eocc = eocc; r.eid = eid; r.est = est; r.cd = cd;
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, iv, ir, input logic [7:0] id);
    flush       = fl;
    up_if.valid = iv;
    up_if.ctrl  = mk_ctrl(id);
    up_if.data  = mk_data(id);
    dn_if.ready = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset with random inputs on every pin.
    for (int c = 0; c < 2; c++) begin
      flush       = 1'($urandom);
      up_if.valid = 1'($urandom);
      up_if.ctrl  = CW'($urandom);
      up_if.data  = {$urandom, $urandom, $urandom, $urandom};
      dn_if.ready = 1'($urandom);
      tick();
    end
    check("rst valid", 128'(dn_if.valid), 128'd0);
    check("rst ctrl",  128'(dn_if.ctrl),  128'd0);
    check("rst data",  dn_if.data,        128'd0);
    check("rst ready", 128'(up_if.ready), 128'd1);
    check("rst occ",   128'(occ),         128'd0);
    check("rst stall", 128'(stall_cnt),   128'd0);
    rst = 1'b0;

    // Streaming 1..8, then stall/skid, in-place replace, flush cases.
    for (int k = 1; k <= 8; k++)
      tbl[k-1] = v(1'b0, 1'b1, 1'b1, 8'(k), 1'b1, 1'b1, 2'd1, 8'(k), 4'd0, 1'b0);
    tbl[8]  = v(0, 0, 1, 8'd0,  0, 1, 2'd0, 8'd0,  4'd0, 0);
    tbl[9]  = v(0, 1, 0, 8'd10, 1, 1, 2'd1, 8'd10, 4'd0, 0);
    tbl[10] = v(0, 1, 0, 8'd11, 1, 0, 2'd2, 8'd10, 4'd1, 0);
    tbl[11] = v(0, 1, 0, 8'd12, 1, 0, 2'd2, 8'd10, 4'd2, 0);
    tbl[12] = v(0, 0, 1, 8'd0,  1, 1, 2'd1, 8'd11, 4'd2, 0);
    tbl[13] = v(0, 0, 1, 8'd0,  0, 1, 2'd0, 8'd0,  4'd2, 0);
    tbl[14] = v(0, 1, 0, 8'd15, 1, 1, 2'd1, 8'd15, 4'd2, 0);
    tbl[15] = v(0, 1, 1, 8'd16, 1, 1, 2'd1, 8'd16, 4'd2, 0);
    tbl[16] = v(0, 1, 0, 8'd17, 1, 0, 2'd2, 8'd16, 4'd3, 0);
    tbl[17] = v(1, 1, 0, 8'd18, 0, 1, 2'd0, 8'd0,  4'd4, 1);
    tbl[18] = v(0, 0, 1, 8'd0,  0, 1, 2'd0, 8'd0,  4'd4, 1);
    tbl[19] = v(0, 1, 1, 8'd20, 1, 1, 2'd1, 8'd20, 4'd4, 0);
    tbl[20] = v(1, 1, 1, 8'd21, 0, 1, 2'd0, 8'd0,  4'd4, 1);
    tbl[21] = v(0, 0, 1, 8'd0,  0, 1, 2'd0, 8'd0,  4'd4, 1);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ir, tbl[i].id);
      tick();
      check($sformatf("row%0d valid", i), 128'(dn_if.valid), 128'(tbl[i].ev));
      check($sformatf("row%0d ready", i), 128'(up_if.ready), 128'(tbl[i].er));
      check($sformatf("row%0d occ", i),   128'(occ),         128'(tbl[i].eocc));
      check($sformatf("row%0d stall", i), 128'(stall_cnt),   128'(tbl[i].est));
      check($sformatf("row%0d ctrl", i),  128'(dn_if.ctrl),
            tbl[i].ev ? 128'(mk_ctrl(tbl[i].eid)) : 128'd0);
      if (tbl[i].ev)
        check($sformatf("row%0d data", i), dn_if.data, mk_data(tbl[i].eid));
      else if (tbl[i].cd)
        check($sformatf("row%0d data0", i), dn_if.data, 128'd0);
    end

    // Stall counter saturation: counter is at 4 here.
    drive(1'b0, 1'b1, 1'b0, 8'd30);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < 10; c++) tick();
    check("sat 14", 128'(stall_cnt), 128'd14);
    tick();
    check("sat 15", 128'(stall_cnt), 128'd15);
    for (int c = 0; c < 9; c++) tick();
    check("sat hold", 128'(stall_cnt), 128'd15);
    check("sat occ",  128'(occ),       128'd1);
    check("sat data", dn_if.data,      mk_data(8'd30));

    drive(1'b1, 1'b1, 1'b0, 8'd31);
    tick();
    check("flush stall", 128'(stall_cnt),   128'd15);
    check("flush occ",   128'(occ),         128'd0);
    check("flush valid", 128'(dn_if.valid), 128'd0);

    // Reset wins over a simultaneous flush and input.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'd32);
    tick();
    check("rst2 stall", 128'(stall_cnt),   128'd0);
    check("rst2 ready", 128'(up_if.ready), 128'd1);
    check("rst2 occ",   128'(occ),         128'd0);
    check("rst2 valid", 128'(dn_if.valid), 128'd0);
    check("rst2 data",  dn_if.data,        128'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
